musa_control_fsm: RTL and testbench
===================================

Name: musa_control_fsm

Overview:
Multicycle control unit for the MUSA core. It sequences every instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the datapath control word (reg_dst, mem_read, mem_to_reg, alu_op, mem_write, reg_write, data_a_s, data_b_s, pc_src, push, pop). It handshakes with data memory (mem_ready) and the multi-cycle MULT/DIV unit (alu_done), and bounds both waits with a timeout. Opcode and funct encodings are the shared MUSA opcode definitions (R_TYPE_OPCODE, LW_OPCODE, MULT_OPCODE, ...).

Parameters:
DATA_WIDTH, 32, instruction width.
WAIT_TIMEOUT, 16, maximum cycles to wait for mem_ready or alu_done before aborting (1..255).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
instruction  in  DATA_WIDTH  instruction word from instruction memory; valid during FETCH
mem_ready  in  1  data memory ack for the current read/write
alu_done  in  1  MULT/DIV completion pulse
ir_write  out  1  latch instruction into the IR (FETCH strobe)
pc_write  out  1  PC update strobe (last cycle of each instruction)
reg_dst  out  1  destination = rd (R-type)
mem_read  out  1  data memory read request (level)
mem_to_reg  out  1  writeback source = memory
alu_op  out  3  ALU operation class
mem_write  out  1  data memory write request (level)
reg_write  out  1  register file write strobe
flag_write  out  1  flag register update strobe (CMP)
data_a_s  out  2  ALU A-operand select
data_b_s  out  2  ALU B-operand select
pc_src  out  3  next-PC source select
push, pop  out  1 each  return stack strobes
alu_start  out  1  MULT/DIV start pulse
timeout_err  out  1  one-cycle pulse on wait abort
illegal_op  out  1  one-cycle pulse on unknown opcode
halted  out  1  sticky, core stopped
state  out  3  FSM state for debug/monitor

Behaviour:
- Reset (async, rst_n=0): state=FETCH, every output 0, wait counter 0. First cycle after release is FETCH.
- States: FETCH(0), DECODE(1), EXECUTE(2), MEMORY(3), WRITEBACK(4), HALT(7).
- FETCH: ir_write=1 for one cycle → DECODE. DECODE: register opcode/funct and compute the control word → EXECUTE, or → HALT for HALT_OPCODE.
- The control word (reg_dst, mem_to_reg, alu_op, data_a_s, data_b_s, pc_src, mem_read, mem_write) is registered on DECODE→EXECUTE and held until the next FETCH. The strobes reg_write, flag_write, push, pop and pc_write are active only in the instruction's last cycle.
- Control words (unlisted fields 0):
  - R-type ADD/SUB/AND/OR/NOT/NOP: reg_dst=1, alu_op=010, data_a_s=10, data_b_s=01, pc_src=010; EXECUTE→WRITEBACK(reg_write).
  - MULT/DIV (R-type funct): same word. alu_start=1 on the first EXECUTE cycle; stay in EXECUTE until alu_done, then WRITEBACK.
  - ADDI/SUBI/ANDI/ORI: data_a_s=10, pc_src=010; →WRITEBACK(reg_write).
  - LW: mem_read=1, mem_to_reg=1, pc_src=010; →MEMORY, wait mem_ready; →WRITEBACK(reg_write). mem_read stays high in WRITEBACK.
  - SW: mem_write=1, data_a_s=10, pc_src=010; →MEMORY; the cycle with mem_ready is the last cycle (pc_write) →FETCH.
  - CMP: alu_op=101, data_a_s=10, data_b_s=01, pc_src=010; flag_write in EXECUTE →FETCH.
  - JPC: data_b_s=01, pc_src=100. BRFL: alu_op=101, data_a_s=10, pc_src=001. JR: pc_src=001. CALL: push=1, pc_src=001. RET: pop=1, pc_src=000. All finish in EXECUTE (pc_write) →FETCH.
  - HALT: pc_src=110, halted=1, no strobes; stays in HALT until reset.
  - Unknown opcode: illegal_op pulse in DECODE; executes as NOP (pc_src=010, pc_write only).
- Latency with zero-wait acks: jumps/branches/CMP 3 cycles; ALU and SW 4; LW and MULT/DIV 5. Every control word is visible within 1..5 cycles after FETCH.
- Wait counter: counts cycles in MEMORY, or in EXECUTE for MULT/DIV, and clears on state exit. If the ack is still absent after WAIT_TIMEOUT cycles, pulse timeout_err, drop mem_read/mem_write, suppress reg_write, pulse pc_write with pc_src=010, →FETCH.
- An ack in the same cycle the counter hits WAIT_TIMEOUT counts as success; no error.
- mem_ready outside MEMORY and alu_done outside MULT/DIV EXECUTE are ignored.
- Reset mid-operation clears immediately; no partial strobe is emitted.

Test Plan:
- R-type ADD → states 0,1,2,4; in cycle 4 reg_dst=1, reg_write=1, alu_op=010, data_a_s=10, data_b_s=01, pc_src=010, pc_write=1.
- LW, mem_ready after 2 wait cycles → mem_read high for 3 MEMORY cycles plus WRITEBACK; reg_write and mem_to_reg=1 in WRITEBACK; 7 cycles total.
- MULT, alu_done 3 cycles after alu_start → single alu_start pulse; reg_write 1 cycle after alu_done.
- SW, mem_ready never → timeout_err after 16 MEMORY cycles; mem_write drops; next state FETCH; reg_write never set.
- CALL then RET → push=1 with pc_src=001 in EXECUTE, then pop=1 with pc_src=000; each 3 cycles.
- HALT → pc_src=110, halted=1 held 20 cycles. rst_n pulsed low mid-LW MEMORY → all outputs 0 immediately; FETCH with ir_write=1 in the first cycle after release.

Source files
------------

// File: rtl/musa_control_fsm.sv
// Multicycle control unit for the MUSA core: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// and drives the datapath control word, with bounded waits on data memory and MULT/DIV.
module musa_control_fsm #(
    parameter int DATA_WIDTH   = 32,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic                  mem_ready,
    input  logic                  alu_done,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_dst,
    output logic                  mem_read,
    output logic                  mem_to_reg,
    output logic [2:0]            alu_op,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  flag_write,
    output logic [1:0]            data_a_s,
    output logic [1:0]            data_b_s,
    output logic [2:0]            pc_src,
    output logic                  push,
    output logic                  pop,
    output logic                  alu_start,
    output logic                  timeout_err,
    output logic                  illegal_op,
    output logic                  halted,
    output logic [2:0]            state
);

    localparam logic [5:0] R_TYPE_OPCODE = 6'b000000;
    localparam logic [5:0] ADDI_OPCODE   = 6'b000001;
    localparam logic [5:0] SUBI_OPCODE   = 6'b000010;
    localparam logic [5:0] ANDI_OPCODE   = 6'b000011;
    localparam logic [5:0] ORI_OPCODE    = 6'b000100;
    localparam logic [5:0] LW_OPCODE     = 6'b000101;
    localparam logic [5:0] SW_OPCODE     = 6'b000110;
    localparam logic [5:0] CMP_OPCODE    = 6'b000111;
    localparam logic [5:0] JPC_OPCODE    = 6'b001000;
    localparam logic [5:0] BRFL_OPCODE   = 6'b001001;
    localparam logic [5:0] JR_OPCODE     = 6'b001010;
    localparam logic [5:0] CALL_OPCODE   = 6'b001011;
    localparam logic [5:0] RET_OPCODE    = 6'b001100;
    localparam logic [5:0] HALT_OPCODE   = 6'b111111;

    localparam logic [5:0] ADD_FUNCT  = 6'b000000;
    localparam logic [5:0] SUB_FUNCT  = 6'b000001;
    localparam logic [5:0] AND_FUNCT  = 6'b000010;
    localparam logic [5:0] OR_FUNCT   = 6'b000011;
    localparam logic [5:0] NOT_FUNCT  = 6'b000100;
    localparam logic [5:0] NOP_FUNCT  = 6'b000101;
    localparam logic [5:0] MULT_FUNCT = 6'b000110;
    localparam logic [5:0] DIV_FUNCT  = 6'b000111;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd7
    } state_t;

    // Instruction class decides the path taken after DECODE.
    typedef enum logic [2:0] {
        K_ALU    = 3'd0,
        K_MULDIV = 3'd1,
        K_LW     = 3'd2,
        K_SW     = 3'd3,
        K_CMP    = 3'd4,
        K_BRANCH = 3'd5,
        K_CALL   = 3'd6,
        K_RET    = 3'd7
    } kind_t;

    typedef struct packed {
        logic       reg_dst;
        logic       mem_to_reg;
        logic [2:0] alu_op;
        logic [1:0] data_a_s;
        logic [1:0] data_b_s;
        logic [2:0] pc_src;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    ctrl_t      cw_q, cw_d;
    logic [5:0] op_q, funct_q;
    logic [7:0] cnt_q, cnt_d;

    ctrl_t      decCw;
    kind_t      decKind;
    logic       decIllegal;
    logic       decHalt;
    logic       abort;
    logic       irWriteC;

    logic       unused_instr;
    assign unused_instr = ^instruction[DATA_WIDTH-7:6];

    // Opcode/funct are captured from instruction memory while the FETCH strobe is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            kind_q  <= K_ALU;
            cw_q    <= '0;
            op_q    <= '0;
            funct_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cw_q    <= cw_d;
            cnt_q   <= cnt_d;
            if (irWriteC) begin
                op_q    <= instruction[DATA_WIDTH-1 -: 6];
                funct_q <= instruction[5:0];
            end
        end
    end

    always_comb begin
        decCw      = '0;
        decKind    = K_BRANCH;
        decIllegal = 1'b0;
        decHalt    = 1'b0;
        case (op_q)
            R_TYPE_OPCODE: begin
                decCw.reg_dst  = 1'b1;
                decCw.alu_op   = 3'b010;
                decCw.data_a_s = 2'b10;
                decCw.data_b_s = 2'b01;
                decCw.pc_src   = 3'b010;
                case (funct_q)
                    ADD_FUNCT, SUB_FUNCT, AND_FUNCT,
                    OR_FUNCT, NOT_FUNCT, NOP_FUNCT: decKind = K_ALU;
                    MULT_FUNCT, DIV_FUNCT:          decKind = K_MULDIV;
                    default: begin
                        decCw      = '0;
                        decCw.pc_src = 3'b010;
                        decIllegal = 1'b1;
                    end
                endcase
            end
            ADDI_OPCODE, SUBI_OPCODE, ANDI_OPCODE, ORI_OPCODE: begin
                decCw.data_a_s = 2'b10;
                decCw.pc_src   = 3'b010;
                decKind        = K_ALU;
            end
            LW_OPCODE: begin
                decCw.mem_read   = 1'b1;
                decCw.mem_to_reg = 1'b1;
                decCw.pc_src     = 3'b010;
                decKind          = K_LW;
            end
            SW_OPCODE: begin
                decCw.mem_write = 1'b1;
                decCw.data_a_s  = 2'b10;
                decCw.pc_src    = 3'b010;
                decKind         = K_SW;
            end
            CMP_OPCODE: begin
                decCw.alu_op   = 3'b101;
                decCw.data_a_s = 2'b10;
                decCw.data_b_s = 2'b01;
                decCw.pc_src   = 3'b010;
                decKind        = K_CMP;
            end
            JPC_OPCODE: begin
                decCw.data_b_s = 2'b01;
                decCw.pc_src   = 3'b100;
            end
            BRFL_OPCODE: begin
                decCw.alu_op   = 3'b101;
                decCw.data_a_s = 2'b10;
                decCw.pc_src   = 3'b001;
            end
            JR_OPCODE: decCw.pc_src = 3'b001;
            CALL_OPCODE: begin
                decCw.pc_src = 3'b001;
                decKind      = K_CALL;
            end
            RET_OPCODE: begin
                decCw.pc_src = 3'b000;
                decKind      = K_RET;
            end
            HALT_OPCODE: begin
                decCw.pc_src = 3'b110;
                decHalt      = 1'b1;
            end
            default: begin
                decCw.pc_src = 3'b010;
                decIllegal   = 1'b1;
            end
        endcase
    end

    // A MULT/DIV done in the start cycle cannot belong to this start, so it is not accepted there.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cw_d        = cw_q;
        cnt_d       = '0;
        irWriteC    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        flag_write  = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        alu_start   = 1'b0;
        timeout_err = 1'b0;
        illegal_op  = 1'b0;
        abort       = 1'b0;
        case (state_q)
            S_FETCH: begin
                irWriteC = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                cw_d       = decCw;
                kind_d     = decKind;
                illegal_op = decIllegal;
                state_d    = decHalt ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (kind_q)
                    K_ALU:        state_d = S_WRITEBACK;
                    K_LW, K_SW:   state_d = S_MEMORY;
                    K_MULDIV: begin
                        alu_start = (cnt_q == 8'd0);
                        if (alu_done && (cnt_q != 8'd0)) begin
                            state_d = S_WRITEBACK;
                        end else if (cnt_q == LAST_WAIT) begin
                            abort = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    K_CMP: begin
                        flag_write = 1'b1;
                        pc_write   = 1'b1;
                        state_d    = S_FETCH;
                    end
                    K_CALL: begin
                        push     = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                    K_RET: begin
                        pop      = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (kind_q == K_LW) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        if (abort) begin
            timeout_err = 1'b1;
            pc_write    = 1'b1;
            state_d     = S_FETCH;
        end
        if (state_d == S_FETCH) begin
            cw_d = '0;
        end
    end

    // ir_write is gated by rst_n so nothing is asserted while the core is held in reset.
    assign ir_write   = irWriteC & rst_n;
    assign reg_dst    = cw_q.reg_dst;
    assign mem_to_reg = cw_q.mem_to_reg;
    assign alu_op     = cw_q.alu_op;
    assign data_a_s   = cw_q.data_a_s;
    assign data_b_s   = cw_q.data_b_s;
    assign mem_read   = cw_q.mem_read & ~abort;
    assign mem_write  = cw_q.mem_write & ~abort;
    assign pc_src     = abort ? 3'b010 : cw_q.pc_src;
    assign halted     = (state_q == S_HALT);
    assign state      = state_q;

endmodule

// File: tb/tb_musa_control_fsm.sv
// Directed bench for musa_control_fsm: walks each instruction class cycle by cycle and
// checks the state and control outputs against hand-computed values.
module tb_musa_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        alu_done;
    logic        ir_write, pc_write, reg_dst, mem_read, mem_to_reg;
    logic [2:0]  alu_op;
    logic        mem_write, reg_write, flag_write;
    logic [1:0]  data_a_s, data_b_s;
    logic [2:0]  pc_src;
    logic        push, pop, alu_start, timeout_err, illegal_op, halted;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] R_OP    = 6'b000000;
    localparam logic [5:0] LW_OP   = 6'b000101;
    localparam logic [5:0] SW_OP   = 6'b000110;
    localparam logic [5:0] CMP_OP  = 6'b000111;
    localparam logic [5:0] CALL_OP = 6'b001011;
    localparam logic [5:0] RET_OP  = 6'b001100;
    localparam logic [5:0] HALT_OP = 6'b111111;
    localparam logic [5:0] BAD_OP  = 6'b010101;
    localparam logic [5:0] ADD_F   = 6'b000000;
    localparam logic [5:0] MULT_F  = 6'b000110;

    musa_control_fsm #(.DATA_WIDTH(32), .WAIT_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .mem_ready(mem_ready), .alu_done(alu_done),
        .ir_write(ir_write), .pc_write(pc_write), .reg_dst(reg_dst),
        .mem_read(mem_read), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .mem_write(mem_write), .reg_write(reg_write), .flag_write(flag_write),
        .data_a_s(data_a_s), .data_b_s(data_b_s), .pc_src(pc_src),
        .push(push), .pop(pop), .alu_start(alu_start),
        .timeout_err(timeout_err), .illegal_op(illegal_op),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    logic [26:0] allOut;
    assign allOut = {state, ir_write, pc_write, reg_dst, mem_read, mem_to_reg, alu_op,
                     mem_write, reg_write, flag_write, data_a_s, data_b_s, pc_src,
                     push, pop, alu_start, timeout_err, illegal_op, halted};

    function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [5:0] funct);
        return {op, 20'b0, funct};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rdy, input logic done);
        mem_ready = rdy;
        alu_done  = done;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        instruction = mkInstr(R_OP, ADD_F);
        mem_ready   = 1'b0;
        alu_done    = 1'b0;
        #3;
        checkOutput("reset_all_zero", 32'(allOut), 32'd0);
        tick();
        checkOutput("reset_held_edge", 32'(allOut), 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("rel_state", 32'(state), 32'd0);
        checkOutput("rel_ir_write", 32'(ir_write), 32'd1);

        // R-type ADD: 0,1,2,4
        tick();
        checkOutput("add_decode", 32'(state), 32'd1);
        checkOutput("add_ir_write_low", 32'(ir_write), 32'd0);
        tick();
        checkOutput("add_exec", 32'(state), 32'd2);
        checkOutput("add_exec_no_wr", 32'({reg_write, pc_write}), 32'd0);
        tick();
        checkOutput("add_wb_state", 32'(state), 32'd4);
        checkOutput("add_wb_word",
                    32'({reg_dst, reg_write, alu_op, data_a_s, data_b_s, pc_src, pc_write}),
                    32'({1'b1, 1'b1, 3'b010, 2'b10, 2'b01, 3'b010, 1'b1}));
        tick();
        checkOutput("add_back_fetch", 32'({state, ir_write, reg_dst}), 32'({3'd0, 1'b1, 1'b0}));

        // LW with two wait cycles
        instruction = mkInstr(LW_OP, 6'd0);
        tick();
        tick();
        checkOutput("lw_exec", 32'(state), 32'd2);
        tick();
        checkOutput("lw_mem1", 32'({state, mem_read, reg_write}), 32'({3'd3, 1'b1, 1'b0}));
        tick();
        checkOutput("lw_mem2", 32'({state, mem_read}), 32'({3'd3, 1'b1}));
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("lw_mem3_ack", 32'({state, mem_read, timeout_err}), 32'({3'd3, 1'b1, 1'b0}));
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("lw_wb", 32'({state, reg_write, mem_to_reg, mem_read, pc_write}),
                    32'({3'd4, 1'b1, 1'b1, 1'b1, 1'b1}));
        tick();
        checkOutput("lw_fetch_7cyc", 32'(state), 32'd0);

        // MULT, alu_done three cycles after alu_start; stray mem_ready ignored
        instruction = mkInstr(R_OP, MULT_F);
        tick();
        tick();
        checkOutput("mult_e1_start", 32'({state, alu_start}), 32'({3'd2, 1'b1}));
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("mult_e2_single_start", 32'({state, alu_start}), 32'({3'd2, 1'b0}));
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("mult_e3_memrdy_ignored", 32'({state, alu_start}), 32'({3'd2, 1'b0}));
        tick();
        applyStimulus(1'b0, 1'b1);
        checkOutput("mult_e4_done", 32'({state, reg_write}), 32'({3'd2, 1'b0}));
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("mult_wb", 32'({state, reg_write, alu_start}), 32'({3'd4, 1'b1, 1'b0}));
        tick();

        // SW with mem_ready never arriving
        instruction = mkInstr(SW_OP, 6'd0);
        tick();
        tick();
        checkOutput("sw_exec", 32'({state, mem_write, data_a_s}), 32'({3'd2, 1'b1, 2'b10}));
        for (int i = 0; i < 15; i++) begin
            tick();
            checkOutput("sw_wait", 32'({state, mem_write, timeout_err, reg_write, pc_write}),
                        32'({3'd3, 1'b1, 1'b0, 1'b0, 1'b0}));
        end
        tick();
        checkOutput("sw_timeout",
                    32'({state, timeout_err, mem_write, pc_write, pc_src, reg_write}),
                    32'({3'd3, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0}));
        tick();
        checkOutput("sw_to_fetch", 32'({state, timeout_err}), 32'({3'd0, 1'b0}));

        // SW acked exactly on the last allowed cycle: success
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("sw_edge_ack", 32'({state, timeout_err, mem_write, pc_write}),
                    32'({3'd3, 1'b0, 1'b1, 1'b1}));
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("sw_edge_fetch", 32'(state), 32'd0);

        // CALL then RET
        instruction = mkInstr(CALL_OP, 6'd0);
        tick();
        tick();
        checkOutput("call_exec", 32'({state, push, pop, pc_src, pc_write}),
                    32'({3'd2, 1'b1, 1'b0, 3'b001, 1'b1}));
        tick();
        instruction = mkInstr(RET_OP, 6'd0);
        checkOutput("call_fetch", 32'(state), 32'd0);
        tick();
        tick();
        checkOutput("ret_exec", 32'({state, push, pop, pc_src, pc_write}),
                    32'({3'd2, 1'b0, 1'b1, 3'b000, 1'b1}));
        tick();

        // CMP and an unknown opcode
        instruction = mkInstr(CMP_OP, 6'd0);
        tick();
        tick();
        checkOutput("cmp_exec", 32'({state, flag_write, alu_op, pc_write, reg_write}),
                    32'({3'd2, 1'b1, 3'b101, 1'b1, 1'b0}));
        tick();
        instruction = mkInstr(BAD_OP, 6'd0);
        tick();
        checkOutput("bad_decode", 32'({state, illegal_op}), 32'({3'd1, 1'b1}));
        tick();
        checkOutput("bad_exec_nop", 32'({state, illegal_op, pc_write, pc_src, reg_write}),
                    32'({3'd2, 1'b0, 1'b1, 3'b010, 1'b0}));
        tick();

        // HALT held, then reset
        instruction = mkInstr(HALT_OP, 6'd0);
        tick();
        tick();
        checkOutput("halt_enter", 32'({state, halted, pc_src, pc_write}),
                    32'({3'd7, 1'b1, 3'b110, 1'b0}));
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("halt_hold", 32'({state, halted, pc_src, ir_write}),
                        32'({3'd7, 1'b1, 3'b110, 1'b0}));
        end
        rst_n = 1'b0;
        #1;
        checkOutput("halt_reset", 32'(allOut), 32'd0);
        instruction = mkInstr(LW_OP, 6'd0);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("lw2_fetch", 32'({state, ir_write}), 32'({3'd0, 1'b1}));
        tick();
        tick();
        tick();
        tick();
        checkOutput("lw2_mem", 32'({state, mem_read}), 32'({3'd3, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("lw2_mid_reset", 32'(allOut), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("lw2_rel_fetch", 32'({state, ir_write}), 32'({3'd0, 1'b1}));
        tick();
        checkOutput("lw2_rel_decode", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
